ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width of operands and results.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  decode stage presents an instruction.
REQ-006 stall  in  1  hold the stage contents.
REQ-007 flush  in  1  replace the stage contents with a bubble.
REQ-008 id_opcode  in  7  RISC-V opcode.
REQ-009 id_funct3  in  3  funct3 field.
REQ-010 id_funct7_5  in  1  instruction bit 30.
REQ-011 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-012 id_rs1_data, id_rs2_data, id_imm  in  XLEN each  register-file read data and sign-extended immediate.
REQ-013 exmem_regwrite  in  1  EX/MEM writeback enable. exmem_rd  in  5  its index. exmem_result  in  XLEN  its value.
REQ-014 memwb_regwrite  in  1  MEM/WB writeback enable. memwb_rd  in  5  its index. memwb_wdata  in  XLEN  its value.
REQ-015 ex_valid  out  1  the stage holds a live instruction.
REQ-016 ALUCtl  out  4  ALU operation code.
REQ-017 A, B  out  XLEN each  ALU operands.
REQ-018 ex_rd  out  5  destination index.
REQ-019 ex_regwrite  out  1  writeback enable.
REQ-020 illegal  out  1  live instruction is not supported.

Function
REQ-021 Register update at each rising clk edge, in priority order:
- flush=1: ex_valid<=0; other fields are don't-care. flush overrides stall.
- else stall=1: all stage registers hold.
- else: all stage registers capture the id_* inputs, and ex_valid<=in_valid.
REQ-022 Decode is performed on the id_* inputs and stored in the stage register, so ALUCtl has one cycle of latency from ID.
REQ-023 R-type (opcode 0110011) decode, funct3 -> ALUCtl:
- 000: 0010 add, or 0110 sub when funct7_5=1.
- 001: 0011 sll.
- 010: 0100 slt.
- 100: 0111 xor.
- 101 with funct7_5=0: 1000 srl.
- 110: 0001 or.
- 111: 0000 and.
REQ-024 I-type (opcode 0010011) uses the same funct3 map, with these differences:
- funct3=000 is always add.
- B is the stored id_imm; for funct3 001 and 101, B = zero-extended imm[5:0].
REQ-025 Unsupported encodings set illegal=1, ALUCtl=0010 and ex_regwrite=0:
- funct3=011.
- funct3=101 with funct7_5=1.
- any other opcode.
REQ-026 ex_regwrite = ex_valid AND not illegal AND (ex_rd != 0).
REQ-027 illegal = 0 whenever ex_valid = 0.
REQ-028 Forwarding is combinational on the stored rs1/rs2 against the current exmem_*/memwb_* inputs:
- EX/MEM match (exmem_regwrite=1, exmem_rd=rs, rs!=0) selects exmem_result.
- Otherwise a MEM/WB match under the same rule selects memwb_wdata.
- Otherwise the stored register data is used.
REQ-029 A = forwarded rs1 value. B = forwarded rs2 value for R-type; the immediate per REQ-024 for I-type.
REQ-030 Index 0 is never forwarded; stored x0 data passes through unchanged.
REQ-031 During stall, forwarding keeps re-evaluating against the changing exmem_*/memwb_* inputs.

Reset
REQ-032 While rst=1, asynchronously: ex_valid=0, ALUCtl=0000, ex_rd=0, ex_regwrite=0, illegal=0, and all stored operand, immediate and index registers=0.
REQ-033 With no forwarding match, A=0 and B=0 after reset.
REQ-034 rst asserted mid-operation discards the held instruction with no completion.
REQ-035 The first capture occurs on the first rising edge after rst deasserts.

Verification
REQ-036 R-type add: opcode 0110011, funct3 000, funct7_5 0, rs1_data=10, rs2_data=5, rd=3 -> next cycle ALUCtl=0010, A=10, B=5, ex_regwrite=1.
REQ-037 Same instruction with funct7_5=1 and rs1_data=rs2_data=100 -> ALUCtl=0110, A=B=100.
REQ-038 I-type slli: funct3 001, imm=0xFFFF_FFFF_FFFF_FFC3 -> ALUCtl=0011, B=3.
REQ-039 Forwarding with rs1=5:
- exmem_rd=5, exmem_result=0xAA, memwb_rd=5, memwb_wdata=0x55 -> A=0xAA.
- exmem_regwrite=0 -> A=0x55.
- rs1=0 -> A = stored data.
REQ-040 Stall then flush:
- stall=1 for 3 cycles -> outputs hold.
- flush and stall asserted together -> next cycle ex_valid=0, ex_regwrite=0.
REQ-041 Illegal encodings and reset:
- funct3=011 or opcode 0000011 -> illegal=1, ex_regwrite=0.
- rst pulsed mid-stream between clock edges -> ex_valid=0 immediately.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// Execute-stage operand register for an RV64 integer pipeline. Decodes the
// ID-stage instruction into an ALU control code, latches it together with
// register indices, register data and the immediate, and resolves data
// hazards by forwarding from the EX/MEM and MEM/WB stages combinationally.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   in_valid           ID presents an instruction
//   stall, flush       hold stage / replace stage with a bubble (flush wins)
//   id_*               decoded fields, register read data and immediate
//   exmem_*, memwb_*   writeback candidates used for forwarding
//   ex_valid           stage holds a live instruction
//   ALUCtl             ALU operation code
//   A, B               forwarded ALU operands
//   ex_rd              destination index
//   ex_regwrite        writeback enable
//   illegal            live instruction is not supported
module ex_operand_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            exmem_regwrite,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_wdata,
    output logic            ex_valid,
    output logic [3:0]      ALUCtl,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite,
    output logic            illegal
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic            valid_q, valid_d;
    logic [3:0]      aluctl_q, aluctl_d;
    logic            illegal_q, illegal_d;
    logic            itype_q, itype_d;
    logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;

    logic            dec_illegal;
    logic [3:0]      dec_aluctl;
    logic            is_r, is_i;
    logic [XLEN-1:0] dec_imm;

    // Decode of the incoming instruction.
    always_comb begin
        is_r        = (id_opcode == OP_R);
        is_i        = (id_opcode == OP_I);
        dec_illegal = 1'b0;
        dec_aluctl  = 4'b0010;
        if (!is_r && !is_i) begin
            dec_illegal = 1'b1;
        end else begin
            unique case (id_funct3)
                3'b000: dec_aluctl = (is_r && id_funct7_5) ? 4'b0110 : 4'b0010;
                3'b001: dec_aluctl = 4'b0011;
                3'b010: dec_aluctl = 4'b0100;
                3'b011: dec_illegal = 1'b1;
                3'b100: dec_aluctl = 4'b0111;
                3'b101: begin
                    if (id_funct7_5) dec_illegal = 1'b1;
                    else             dec_aluctl  = 4'b1000;
                end
                3'b110: dec_aluctl = 4'b0001;
                3'b111: dec_aluctl = 4'b0000;
                default: dec_illegal = 1'b1;
            endcase
        end
        if (dec_illegal) dec_aluctl = 4'b0010;
        // Shift-immediate forms only use the 6-bit shamt, zero-extended.
        if (is_i && (id_funct3 == 3'b001 || id_funct3 == 3'b101))
            dec_imm = {{(XLEN-6){1'b0}}, id_imm[5:0]};
        else
            dec_imm = id_imm;
    end

    // Stage register next state: flush > stall > capture.
    always_comb begin
        valid_d    = valid_q;
        aluctl_d   = aluctl_q;
        illegal_d  = illegal_q;
        itype_d    = itype_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            aluctl_d   = dec_aluctl;
            illegal_d  = dec_illegal;
            itype_d    = is_i;
            rd_d       = id_rd;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = dec_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            aluctl_q   <= 4'b0000;
            illegal_q  <= 1'b0;
            itype_q    <= 1'b0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            aluctl_q   <= aluctl_d;
            illegal_q  <= illegal_d;
            itype_q    <= itype_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_regwrite && exmem_rd == rs1_q && rs1_q != 5'd0)
            fwd_rs1 = exmem_result;
        else if (memwb_regwrite && memwb_rd == rs1_q && rs1_q != 5'd0)
            fwd_rs1 = memwb_wdata;

        fwd_rs2 = rs2_data_q;
        if (exmem_regwrite && exmem_rd == rs2_q && rs2_q != 5'd0)
            fwd_rs2 = exmem_result;
        else if (memwb_regwrite && memwb_rd == rs2_q && rs2_q != 5'd0)
            fwd_rs2 = memwb_wdata;
    end

    assign ex_valid    = valid_q;
    assign ALUCtl      = aluctl_q;
    assign ex_rd       = rd_q;
    assign A           = fwd_rs1;
    assign B           = itype_q ? imm_q : fwd_rs2;
    // Stored illegal flag is masked so a bubble never reports illegal.
    assign illegal     = valid_q & illegal_q;
    assign ex_regwrite = valid_q & ~illegal_q & (rd_q != 5'd0);

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, stall, flush;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_result, memwb_wdata;
    logic        ex_valid, ex_regwrite, illegal;
    logic [3:0]  ALUCtl;
    logic [63:0] A, B;
    logic [4:0]  ex_rd;

    int total = 0;
    int bad   = 0;

    ex_operand_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .ex_valid(ex_valid), .ALUCtl(ALUCtl), .A(A), .B(B), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference model: the raw instruction latched in EX, decoded on demand.
    logic        mv;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic        m_f75;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [63:0] m_d1, m_d2, m_imm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_illegal(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        if (op != 7'b0110011 && op != 7'b0010011) return 1'b1;
        if (f3 == 3'd3) return 1'b1;
        if (f3 == 3'd5 && f75) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        logic [3:0] tbl [8];
        tbl = '{4'd2, 4'd3, 4'd4, 4'd2, 4'd7, 4'd8, 4'd1, 4'd0};
        if (ref_illegal(op, f3, f75)) return 4'd2;
        if (f3 == 3'd0 && op == 7'b0110011 && f75) return 4'd6;
        return tbl[f3];
    endfunction

    function automatic logic [63:0] ref_fwd(input logic [4:0] rs, input logic [63:0] d);
        if (rs == 0) return d;
        if (exmem_regwrite && exmem_rd == rs) return exmem_result;
        if (memwb_regwrite && memwb_rd == rs) return memwb_wdata;
        return d;
    endfunction

    task automatic model_reset();
        mv = 0; m_op = 0; m_f3 = 0; m_f75 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0;
    endtask

    task automatic check_all();
        bit ill;
        logic [63:0] eb;
        ill = ref_illegal(m_op, m_f3, m_f75);
        chk("ex_valid", ex_valid, mv);
        chk("illegal", illegal, mv & ill);
        chk("ex_regwrite", ex_regwrite, mv & !ill & (m_rd != 0));
        if (mv) begin
            chk("ALUCtl", ALUCtl, ref_alu(m_op, m_f3, m_f75));
            chk("ex_rd", ex_rd, m_rd);
            chk("A", A, ref_fwd(m_rs1, m_d1));
            if (m_op == 7'b0010011)
                eb = (m_f3 == 3'd1 || m_f3 == 3'd5) ? {58'd0, m_imm[5:0]} : m_imm;
            else
                eb = ref_fwd(m_rs2, m_d2);
            chk("B", B, eb);
        end
    endtask

    // One clock: model follows the same edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (flush) mv = 0;
        else if (!stall) begin
            mv = in_valid; m_op = id_opcode; m_f3 = id_funct3; m_f75 = id_funct7_5;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
        end
        #1 check_all();
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm);
        in_valid = 1; id_opcode = op; id_funct3 = f3; id_funct7_5 = f75;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; stall = 0; flush = 0;
        id_opcode = 0; id_funct3 = 0; id_funct7_5 = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ex_valid", ex_valid, 0);
        chk("rst ALUCtl", ALUCtl, 0);
        chk("rst ex_rd", ex_rd, 0);
        chk("rst regwrite", ex_regwrite, 0);
        chk("rst illegal", illegal, 0);
        chk("rst A", A, 0);
        chk("rst B", B, 0);
        rst = 0;

        // R-type add / sub
        set_instr(7'b0110011, 3'd0, 0, 5'd1, 5'd2, 5'd3, 64'd10, 64'd5, 64'd0);
        step();
        chk("add ALUCtl", ALUCtl, 4'b0010);
        chk("add A", A, 64'd10);
        chk("add B", B, 64'd5);
        chk("add regwrite", ex_regwrite, 1);
        set_instr(7'b0110011, 3'd0, 1, 5'd1, 5'd2, 5'd3, 64'd100, 64'd100, 64'd0);
        step();
        chk("sub ALUCtl", ALUCtl, 4'b0110);
        chk("sub A", A, 64'd100);
        chk("sub B", B, 64'd100);

        // slli with a negative immediate: only shamt survives
        set_instr(7'b0010011, 3'd1, 0, 5'd1, 5'd2, 5'd3, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFC3);
        step();
        chk("slli ALUCtl", ALUCtl, 4'b0011);
        chk("slli B", B, 64'd3);

        // Forwarding priority on rs1=5
        exmem_regwrite = 1; exmem_rd = 5; exmem_result = 64'hAA;
        memwb_regwrite = 1; memwb_rd = 5; memwb_wdata = 64'h55;
        set_instr(7'b0110011, 3'd0, 0, 5'd5, 5'd6, 5'd3, 64'h1234, 64'd7, 64'd0);
        step();
        chk("fwd exmem", A, 64'hAA);
        exmem_regwrite = 0;
        #1 chk("fwd memwb", A, 64'h55);
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        set_instr(7'b0110011, 3'd0, 0, 5'd0, 5'd6, 5'd3, 64'h1234, 64'd7, 64'd0);
        step();
        chk("fwd x0", A, 64'h1234);
        exmem_regwrite = 0; memwb_regwrite = 0;

        // Stall holds; forwarding keeps tracking; flush beats stall
        set_instr(7'b0110011, 3'd6, 0, 5'd9, 5'd10, 5'd7, 64'd77, 64'd88, 64'd0);
        step();
        stall = 1;
        set_instr(7'b0110011, 3'd7, 0, 5'd1, 5'd1, 5'd1, 64'd1, 64'd1, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall ALUCtl", ALUCtl, 4'b0001);
            chk("stall A", A, 64'd77);
            chk("stall rd", ex_rd, 5'd7);
        end
        memwb_regwrite = 1; memwb_rd = 10; memwb_wdata = 64'h99;
        #1 chk("stall fwd B", B, 64'h99);
        memwb_regwrite = 0;
        flush = 1;
        step();
        chk("flush valid", ex_valid, 0);
        chk("flush regwrite", ex_regwrite, 0);
        flush = 0; stall = 0;

        // Illegal encodings
        set_instr(7'b0110011, 3'd3, 0, 5'd1, 5'd2, 5'd4, 64'd1, 64'd2, 64'd0);
        step();
        chk("ill f3 illegal", illegal, 1);
        chk("ill f3 regwrite", ex_regwrite, 0);
        set_instr(7'b0000011, 3'd0, 0, 5'd1, 5'd2, 5'd4, 64'd1, 64'd2, 64'd0);
        step();
        chk("ill op illegal", illegal, 1);
        chk("ill op ALUCtl", ALUCtl, 4'b0010);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0, 1: id_opcode = 7'b0110011;
                2:    id_opcode = 7'b0010011;
                default: id_opcode = 7'($urandom);
            endcase
            in_valid = ($urandom_range(0, 9) < 8);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
            id_imm = {$urandom, $urandom};
            exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
            exmem_result = {$urandom, $urandom};
            memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_wdata = {$urandom, $urandom};
            step();
        end

        // Asynchronous reset between edges, then first capture after release
        stall = 0; flush = 0;
        exmem_regwrite = 0; memwb_regwrite = 0;
        set_instr(7'b0110011, 3'd0, 0, 5'd1, 5'd2, 5'd3, 64'd4, 64'd5, 64'd0);
        step();
        #2 rst = 1;
        #1 chk("async rst valid", ex_valid, 0);
        chk("async rst regwrite", ex_regwrite, 0);
        chk("async rst ALUCtl", ALUCtl, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        step();
        chk("post rst capture", ex_valid, 1);
        chk("post rst A", A, 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
